// File: rtl/data_mem_unit.sv
// Data-memory responder for the RV32I core: byte/half/word loads and stores on a word array.
// Optional MISALIGNED_SPLIT_EN splits word-crossing accesses into two word accesses; otherwise they fault.
module data_mem_unit #(
  parameter int DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Req,
  input  logic        DMWr,
  input  logic [2:0]  DMCtrl,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  output logic [31:0] DataRd,
  output logic        Done,
  output logic        Fault,
  output logic        Stall
);
  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef MISALIGNED_SPLIT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SPLIT = 2'd1, RESP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_t;
`endif

  state_t        state_q, state_d;
  logic [31:0]   data_rd_q, data_d;
  logic          fault_q, fault_d;
  logic [31:0]   mem [DEPTH_WORDS];

  logic [1:0]    off;
  logic [AW-1:0] idx, idx_hi;
  logic [3:0]    base_mask;
  logic [7:0]    mask;
  logic [63:0]   wr64;
  logic [31:0]   rd_lo, raw, load_ext;
  logic          illegal, misalign, reject;
  logic          we_lo, we_hi;
  logic          unused_addr;

  assign off         = Address[1:0];
  assign idx         = Address[AW+1:2];
  assign idx_hi      = idx + AW'(1);
  assign unused_addr = ^Address[31:AW+2];

  always_comb begin
    case (DMCtrl[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  // Two-word view: lanes 0-3 belong to word N, lanes 4-7 to word N+1.
  assign mask = {4'b0000, base_mask} << off;
  assign wr64 = {32'h0, DataWr} << {off, 3'b000};

  assign illegal  = DMWr ? (DMCtrl[2] || (DMCtrl[1:0] == 2'b11))
                         : ((DMCtrl[1:0] == 2'b11) || (DMCtrl[2] && DMCtrl[1]));
  assign misalign = ((DMCtrl[1:0] == 2'b01) && (off == 2'b11)) ||
                    ((DMCtrl[1:0] == 2'b10) && (off != 2'b00));

`ifdef MISALIGNED_SPLIT_EN
  logic [31:0] lo_q, lo_d;
  assign reject = illegal;
  assign rd_lo  = (state_q == SPLIT) ? lo_q : mem[idx];
`else
  assign reject = illegal || misalign;
  assign rd_lo  = mem[idx];
`endif

  assign raw = 32'({mem[idx_hi], rd_lo} >> {off, 3'b000});

  always_comb begin
    case (DMCtrl)
      3'b000:  load_ext = {{24{raw[7]}}, raw[7:0]};
      3'b001:  load_ext = {{16{raw[15]}}, raw[15:0]};
      3'b100:  load_ext = {24'h0, raw[7:0]};
      3'b101:  load_ext = {16'h0, raw[15:0]};
      default: load_ext = raw;
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_rd_q;
    fault_d = 1'b0;
    we_lo   = 1'b0;
    we_hi   = 1'b0;
`ifdef MISALIGNED_SPLIT_EN
    lo_d    = lo_q;
`endif
    case (state_q)
      IDLE: begin
        if (Req) begin
          if (reject) begin
            fault_d = 1'b1;
            data_d  = '0;
            state_d = RESP;
          end
`ifdef MISALIGNED_SPLIT_EN
          else if (misalign) begin
            we_lo   = DMWr && rst_n;
            lo_d    = mem[idx];
            state_d = SPLIT;
          end
`endif
          else begin
            we_lo   = DMWr && rst_n;
            data_d  = DMWr ? '0 : load_ext;
            state_d = RESP;
          end
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      SPLIT: begin
        we_hi   = DMWr && rst_n;
        data_d  = DMWr ? '0 : load_ext;
        state_d = RESP;
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      data_rd_q <= '0;
      fault_q   <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
      lo_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      data_rd_q <= data_d;
      fault_q   <= fault_d;
`ifdef MISALIGNED_SPLIT_EN
      lo_q      <= lo_d;
`endif
    end
  end

  // Memory is deliberately outside the reset domain; contents survive reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_lo && mask[b])     mem[idx][8*b +: 8]    <= wr64[8*b +: 8];
      if (we_hi && mask[b + 4]) mem[idx_hi][8*b +: 8] <= wr64[32 + 8*b +: 8];
    end
  end

  assign DataRd = data_rd_q;
  assign Done   = (state_q == RESP);
  assign Fault  = fault_q;
  assign Stall  = Req && !Done;
endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

- Data-memory responder for the RV32I core.
- Receives the memory-control bundle the control unit produces: `DMWr`, plus `DMCtrl` carrying funct3. With the request it also receives the ALU-computed address and the store data.
- Performs byte/half/word stores and sign- or zero-extended loads on an internal word array.
- Holds the core with `Stall` until the access completes. Misaligned accesses are split into two word accesses.

## Interface
- `DEPTH_WORDS`, 256: number of 32-bit words; power of two, ≥ 2.
- `clk` input 1: clock, all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `Req` input 1: access request. Held high, with all other inputs stable, while `Stall`=1.
- `DMWr` input 1: 1 = store, 0 = load.
- `DMCtrl` input 3: access type, funct3 encoding.
  - 000 byte, 001 half, 010 word.
  - 100 byte unsigned, 101 half unsigned (loads only).
- `Address` input 32: byte address.
- `DataWr` input 32: store data; low byte/half used for byte/half stores.
- `DataRd` output 32: load result, registered.
- `Done` output 1: one-cycle completion pulse.
- `Fault` output 1: valid with `Done`; access rejected.
- `Stall` output 1: combinational, `Req && !Done`.

## Operation
- Memory is little-endian. Word index = `Address[log2(DEPTH_WORDS)+1:2]`; upper address bits are ignored, so addresses wrap modulo the array size.
- Legal `DMCtrl` values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other value gives `Fault`=1 with no write, and `DataRd`=0.
- An access is misaligned when it crosses a word boundary:
  - half at byte offset 3;
  - word at byte offset 1, 2 or 3.
- FSM states: IDLE, SPLIT, RESP.
  - IDLE, `Req`=1, aligned or fault → RESP. Aligned store writes its byte lanes at this edge.
  - IDLE, `Req`=1, misaligned → SPLIT. Lanes in word N are written, or word N is latched for a load.
  - SPLIT → RESP. Remaining lanes go to word N+1; word index DEPTH_WORDS-1 wraps to 0. Load data is assembled from both words.
  - RESP: `Done`=1 for one cycle → IDLE. `Req` is not sampled in RESP; a held `Req` starts a new access in the following IDLE cycle.
- Load result is extended to 32 bits: sign-extended for 000/001, zero-extended for 100/101. On a store `Done`, `DataRd`=0.
- `DataRd` holds its value between `Done` pulses.
- Store lanes outside the addressed bytes are unchanged.

## Timing
- Reset (async assert) values:
  - state IDLE, `DataRd`=0, `Done`=0, `Fault`=0.
  - `Stall` follows `Req`.
  - Memory contents are not reset.
- Latency from the accepting edge:
  - aligned/fault: `Done` at the next cycle (1-cycle stall);
  - misaligned: `Done` one cycle later (2-cycle stall).
- Back-to-back: the minimum request spacing is accept, RESP, accept, i.e. one access per 2 cycles aligned.
- Reset asserted in SPLIT: the second half is abandoned and the first-half write is retained. No `Done` is issued.
- `Req` dropping mid-access is a protocol violation; the block completes the access regardless.

## Configuration
- `MISALIGNED_SPLIT_EN` defined: misaligned accesses are split as above.
- Not defined:
  - SPLIT state is absent.
  - A misaligned access is treated as a fault: 1-cycle latency, `Fault`=1, no write, `DataRd`=0.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10:
  - each `Done` arrives one cycle after acceptance;
  - `DataRd`=0xDEADBEEF, `Fault`=0.
- After the above:
  - LB @0x13 → 0xFFFFFFDE;
  - LBU @0x13 → 0x000000DE;
  - LH @0x12 → 0xFFFFDEAD;
  - LHU @0x12 → 0x0000DEAD.
- SH 0x1234 @0x10 then LW @0x10 → 0xDEAD1234. Adjacent word 0x14 is unchanged.
- With macro: SW 0xAABBCCDD @0x0E, then LW @0x0E.
  - Each access gives `Done` two cycles after acceptance.
  - Load returns 0xAABBCCDD; LH @0x0E = 0xFFFFCCDD.
  - Same store at the last word's offset 2 wraps into word 0.
- Without macro: LW @0x0E gives `Fault`=1, `DataRd`=0, and memory is unchanged.
- Faults and reset:
  - Load `DMCtrl`=011 or store `DMCtrl`=100 gives `Fault`=1 after one cycle with no memory change.
  - `rst_n` pulsed during SPLIT of a misaligned store: no `Done`, only word N is modified, and the FSM is back in IDLE.
